aeolus_exec_ctrl: RTL and testbench

Execution controller that sequences the Aeolus CPU core through four phases: program load, reset release, run or single-step, and result capture.
Sits between board I/O and the CPU. It owns the CPU clock enable and the CPU reset, writes program bytes into instruction memory, and latches cpuOut when execution ends.
Bounds every run with a cycle budget, replacing fixed-delay run windows.

---
 rtl/aeolus_exec_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_aeolus_exec_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aeolus_exec_ctrl.sv
// Execution controller for the Aeolus core: program load, CPU reset release, run or single-step, result capture.
// Define AEOLUS_CYCLE_COUNT_EN to add the saturating cycleCount output.
module aeolus_exec_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int PROG_LEN     = 16,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 330
) (
  input  logic              boardCLK,
  input  logic              reset,
  input  logic              start,
  input  logic              stepMode,
  input  logic              stepReq,
  input  logic              haltReq,
  input  logic              loadValid,
  input  logic [7:0]        loadData,
  output logic              loadReady,
  input  logic [7:0]        cpuOut,
  input  logic              cpuHalted,
  output logic              imemWe,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [7:0]        imemWData,
  output logic              cpuClkEn,
  output logic              cpuReset,
  output logic [7:0]        resultOut,
  output logic              resultValid,
  output logic              busy,
  output logic              timeout
`ifdef AEOLUS_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycleCount
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_STEP    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // One counter serves both the release window and the run budget.
  localparam int CNT_MAX = (MAX_CYCLES > RESET_CYCLES) ? MAX_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              load_ready_reg, load_ready_next;
  logic              cpu_clk_en_reg, cpu_clk_en_next;
  logic              cpu_reset_reg, cpu_reset_next;
  logic [7:0]        result_out_reg, result_out_next;
  logic              result_valid_reg, result_valid_next;
  logic              busy_reg, busy_next;
  logic              timeout_reg, timeout_next;
  logic              step_req_d_reg;

  logic              step_edge;
  logic              load_accept;
  logic              go_load;
  logic              enter_done;

  assign step_edge   = stepReq & ~step_req_d_reg;
  assign load_accept = loadValid & load_ready_reg;
  assign go_load     = start & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));

  assign imemWe    = load_accept;
  assign imemAddr  = addr_reg;
  assign imemWData = loadData;

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      cnt_reg          <= '0;
      load_ready_reg   <= 1'b0;
      cpu_clk_en_reg   <= 1'b0;
      cpu_reset_reg    <= 1'b1;
      result_out_reg   <= '0;
      result_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      timeout_reg      <= 1'b0;
      step_req_d_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      cnt_reg          <= cnt_next;
      load_ready_reg   <= load_ready_next;
      cpu_clk_en_reg   <= cpu_clk_en_next;
      cpu_reset_reg    <= cpu_reset_next;
      result_out_reg   <= result_out_next;
      result_valid_reg <= result_valid_next;
      busy_reg         <= busy_next;
      timeout_reg      <= timeout_next;
      step_req_d_reg   <= stepReq;
    end
  end

  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    cnt_next          = cnt_reg;
    load_ready_next   = load_ready_reg;
    cpu_clk_en_next   = cpu_clk_en_reg;
    cpu_reset_next    = cpu_reset_reg;
    result_out_next   = result_out_reg;
    result_valid_next = result_valid_reg;
    busy_next         = busy_reg;
    timeout_next      = timeout_reg;
    enter_done        = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (go_load) begin
          state_next        = ST_LOAD;
          load_ready_next   = 1'b1;
          busy_next         = 1'b1;
          addr_next         = '0;
          cnt_next          = '0;
          cpu_clk_en_next   = 1'b0;
          cpu_reset_next    = 1'b1;
          result_valid_next = 1'b0;
          timeout_next      = 1'b0;
        end
      end

      ST_LOAD: begin
        if (load_accept) begin
          addr_next = addr_reg + 1'b1;
          if (addr_reg == ADDR_W'(PROG_LEN - 1)) begin
            load_ready_next = 1'b0;
            cpu_clk_en_next = 1'b1;
            cnt_next        = '0;
            state_next      = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        // stepMode is only looked at on the final release cycle.
        if (cnt_reg == CNT_W'(RESET_CYCLES - 1)) begin
          cnt_next       = '0;
          cpu_reset_next = 1'b0;
          if (stepMode) begin
            state_next      = ST_STEP;
            cpu_clk_en_next = 1'b0;
          end else begin
            state_next      = ST_RUN;
            cpu_clk_en_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_RUN, ST_STEP: begin
        cpu_clk_en_next = (state_reg == ST_RUN) ? 1'b1 : step_edge;
        if (cpu_clk_en_reg) begin
          cnt_next = cnt_reg + 1'b1;
        end
        // cpuHalted outranks haltReq, which outranks the budget.
        if (cpu_clk_en_reg && cpuHalted) begin
          enter_done   = 1'b1;
          timeout_next = 1'b0;
        end else if (haltReq) begin
          enter_done   = 1'b1;
          timeout_next = 1'b0;
        end else if (cpu_clk_en_reg && (cnt_reg == CNT_W'(MAX_CYCLES - 1))) begin
          enter_done   = 1'b1;
          timeout_next = 1'b1;
        end
        if (enter_done) begin
          state_next        = ST_DONE;
          result_out_next   = cpuOut;
          result_valid_next = 1'b1;
          cpu_clk_en_next   = 1'b0;
          busy_next         = 1'b0;
        end
      end

      default: begin
        state_next      = ST_IDLE;
        load_ready_next = 1'b0;
        cpu_clk_en_next = 1'b0;
        cpu_reset_next  = 1'b1;
        busy_next       = 1'b0;
      end
    endcase
  end

  assign loadReady   = load_ready_reg;
  assign cpuClkEn    = cpu_clk_en_reg;
  assign cpuReset    = cpu_reset_reg;
  assign resultOut   = result_out_reg;
  assign resultValid = result_valid_reg;
  assign busy        = busy_reg;
  assign timeout     = timeout_reg;

`ifdef AEOLUS_CYCLE_COUNT_EN
  logic [31:0] enabled_total;
  logic [15:0] cycle_count_reg;

  // Includes the enabled cycle on which DONE is being entered.
  assign enabled_total = 32'(cnt_reg) + 32'(cpu_clk_en_reg);

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      cycle_count_reg <= '0;
    end else if (go_load) begin
      cycle_count_reg <= '0;
    end else if (enter_done) begin
      cycle_count_reg <= (enabled_total > 32'h0000_FFFF) ? 16'hFFFF : enabled_total[15:0];
    end
  end

  assign cycleCount = cycle_count_reg;
`endif

endmodule

// File: tb/tb_aeolus_exec_ctrl.sv
// Self-checking bench for aeolus_exec_ctrl: table of run/step scenarios plus reset and idle corner sequences.
module tb_aeolus_exec_ctrl;

  localparam int ADDR_W       = 4;
  localparam int PROG_LEN     = 16;
  localparam int RESET_CYCLES = 2;
  localparam int MAX_CYCLES   = 330;

  logic              boardCLK = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stepMode = 1'b0;
  logic              stepReq = 1'b0;
  logic              haltReq = 1'b0;
  logic              loadValid = 1'b0;
  logic [7:0]        loadData = '0;
  logic              loadReady;
  logic [7:0]        cpuOut = '0;
  logic              cpuHalted = 1'b0;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [7:0]        imemWData;
  logic              cpuClkEn;
  logic              cpuReset;
  logic [7:0]        resultOut;
  logic              resultValid;
  logic              busy;
  logic              timeout;
`ifdef AEOLUS_CYCLE_COUNT_EN
  logic [15:0]       cycleCount;
`endif

  always #5 boardCLK = ~boardCLK;

  aeolus_exec_ctrl #(
    .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .RESET_CYCLES(RESET_CYCLES), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .boardCLK(boardCLK), .reset(reset), .start(start), .stepMode(stepMode),
    .stepReq(stepReq), .haltReq(haltReq), .loadValid(loadValid), .loadData(loadData),
    .loadReady(loadReady), .cpuOut(cpuOut), .cpuHalted(cpuHalted), .imemWe(imemWe),
    .imemAddr(imemAddr), .imemWData(imemWData), .cpuClkEn(cpuClkEn), .cpuReset(cpuReset),
    .resultOut(resultOut), .resultValid(resultValid), .busy(busy), .timeout(timeout)
`ifdef AEOLUS_CYCLE_COUNT_EN
    , .cycleCount(cycleCount)
`endif
  );

  typedef struct {
    logic       step_mode;
    logic [7:0] cpu_out;
    int         halt_at;     // enabled cycle on which cpuHalted pulses, 0 = never
    int         hreq_at;     // phase cycle on which haltReq pulses, 0 = never
    int         pw;          // stepReq pulse width; pulses repeat every pw+3 cycles
    logic       exp_timeout;
    int         exp_cycles;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  vec_t vecs[9];
  wr_t  wr_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge boardCLK);
  endtask

  // Starts from IDLE/DONE, streams PROG_LEN bytes, returns on the first RELEASE cycle.
  task automatic do_load(input logic [7:0] base);
    wr_t w;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ready", loadReady, 1);
    chk("load_busy", busy, 1);
    chk("load_cpu_reset", cpuReset, 1);
    chk("load_clk_en", cpuClkEn, 0);
    chk("load_rvalid", resultValid, 0);
    chk("load_timeout", timeout, 0);
    for (int i = 0; i < PROG_LEN; i++) begin
      loadValid = 1'b1;
      loadData  = base + 8'(i);
      wr_q.push_back('{addr: ADDR_W'(i), data: base + 8'(i)});
      #1;
      if (imemWe) begin
        w = wr_q.pop_front();
        chk("wr_addr", imemAddr, w.addr);
        chk("wr_data", imemWData, w.data);
      end else begin
        chk("wr_en", imemWe, 1);
      end
      tick();
    end
    #1;
    chk("extra_byte_we", imemWe, 0);
    chk("ready_after_load", loadReady, 0);
    chk("wr_q_empty", wr_q.size(), 0);
    loadValid = 1'b0;
    $display("load base=%02h done", base);
  endtask

  // Counts the cycles with cpuReset and cpuClkEn both high; returns on the first RUN/STEP cycle.
  task automatic do_release(input logic exp_run_en);
    int rel = 0;
    for (int k = 0; k < 10 && cpuReset; k++) begin
      if (cpuClkEn && busy) rel++;
      tick();
    end
    chk("release_cycles", rel, RESET_CYCLES);
    chk("release_cpu_reset", cpuReset, 0);
    chk("release_clk_en", cpuClkEn, exp_run_en);
    chk("release_busy", busy, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   c = 1;
    int   en_cnt = 0;
    int   dbl = 0;
    logic prev_en = 1'b0;
    logic en;
    logic finished = 1'b0;
    stepMode = v.step_mode;
    do_load(8'(idx * 16));
    do_release(!v.step_mode);
    stepMode = ~v.step_mode;
    cpuOut   = v.cpu_out;
    for (int k = 0; k < 4000; k++) begin
      en = cpuClkEn && !cpuReset;
      if (en) en_cnt++;
      if (en && prev_en && v.step_mode) dbl++;
      prev_en   = en;
      stepReq   = v.step_mode && (((c - 1) % (v.pw + 3)) < v.pw);
      cpuHalted = en ? (en_cnt == v.halt_at) : v.step_mode;
      haltReq   = (c == v.hreq_at);
      tick();
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      c++;
    end
    stepReq = 1'b0; cpuHalted = 1'b0; haltReq = 1'b0;
    chk("done_reached", finished, 1);
    chk("enabled_cycles", en_cnt, v.exp_cycles);
    chk("result_out", resultOut, v.cpu_out);
    chk("result_valid", resultValid, 1);
    chk("timeout", timeout, v.exp_timeout);
    chk("done_clk_en", cpuClkEn, 0);
    chk("done_cpu_reset", cpuReset, 0);
    if (v.step_mode) chk("step_single_cycle", dbl, 0);
`ifdef AEOLUS_CYCLE_COUNT_EN
    chk("cycle_count", cycleCount, v.exp_cycles);
`endif
    cpuOut = ~v.cpu_out;
    repeat (3) tick();
    chk("result_hold", resultOut, v.cpu_out);
    chk("done_idle_busy", busy, 0);
    $display("vec %0d: step=%0d result=%02h timeout=%0d cycles=%0d", idx, v.step_mode, resultOut, timeout, en_cnt);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cpu_reset"}, cpuReset, 1);
    chk({tag, "_clk_en"}, cpuClkEn, 0);
    chk({tag, "_load_ready"}, loadReady, 0);
    chk({tag, "_result_out"}, resultOut, 0);
    chk({tag, "_result_valid"}, resultValid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_imem_we"}, imemWe, 0);
    chk({tag, "_imem_addr"}, imemAddr, 0);
`ifdef AEOLUS_CYCLE_COUNT_EN
    chk({tag, "_cycle_count"}, cycleCount, 0);
`endif
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hE1, 50,  0,   1,  1'b0, 50};
    vecs[1] = '{1'b0, 8'h3C, 0,   0,   1,  1'b1, 330};
    vecs[2] = '{1'b0, 8'h5A, 0,   120, 1,  1'b0, 120};
    vecs[3] = '{1'b0, 8'h77, 330, 0,   1,  1'b0, 330};
    vecs[4] = '{1'b0, 8'h99, 1,   0,   1,  1'b0, 1};
    vecs[5] = '{1'b1, 8'hA5, 0,   20,  1,  1'b0, 5};
    vecs[6] = '{1'b1, 8'h42, 3,   0,   10, 1'b0, 3};
    vecs[7] = '{1'b1, 8'h11, 0,   8,   1,  1'b0, 2};
    vecs[8] = '{1'b1, 8'hC3, 0,   0,   2,  1'b1, 330};

    repeat (3) tick();
    #1;
    chk_reset_values("por");
    reset = 1'b1;
    tick();

    // stepReq/haltReq in IDLE must not wake anything up
    haltReq = 1'b1; stepReq = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    chk("idle_clk_en", cpuClkEn, 0);
    chk("idle_load_ready", loadReady, 0);
    haltReq = 1'b0; stepReq = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // start ignored in RUN, then reset mid-RUN
    stepMode = 1'b0;
    do_load(8'hB0);
    do_release(1'b1);
    start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    chk("run_start_ignored_busy", busy, 1);
    chk("run_start_ignored_clk_en", cpuClkEn, 1);
    chk("run_start_ignored_load_ready", loadReady, 0);
    reset = 1'b0;
    #1;
    chk_reset_values("mid_run");
    tick();
    reset = 1'b1;
    tick();

    // reset mid-LOAD: address returns to 0 at once
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      loadValid = 1'b1;
      loadData  = 8'(8'h60 + i);
      tick();
    end
    #1;
    chk("partial_addr", imemAddr, 5);
    reset = 1'b0;
    #1;
    chk_reset_values("mid_load");
    loadValid = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    run_vec(9, '{1'b0, 8'h5E, 0, 40, 1, 1'b0, 40});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
